// File: rtl/list_prefetch.sv
// list_prefetch: fetches list elements ahead of demand into a small FIFO and serves the consumer from it.
// Define LIST_PREFETCH_COUNT_EN to add the saturating 'delivered' element counter output.
module list_prefetch #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clock,
    input  logic             ready,
    output logic             src_req,
    input  logic             src_ack,
    input  logic [WIDTH-1:0] src_value,
    input  logic             src_value_valid,
    input  logic             req,
    output logic             ack,
    output logic [WIDTH-1:0] value,
    output logic             value_valid
`ifdef LIST_PREFETCH_COUNT_EN
    ,
    output logic [15:0]      delivered
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP
    } fetch_state_t;

    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             end_seen;
    logic             pending;
    logic             last_req;
    fetch_state_t     state;

    logic push;
    logic pop;
    logic end_ack;
    logic req_edge;

    assign push     = (state == REQ) && src_ack && src_value_valid;
    assign pop      = pending && (count != '0);
    assign end_ack  = pending && (count == '0) && end_seen;
    assign req_edge = req && !last_req;

    // Tracked even in reset so a request held high across reset release is not an edge.
    always_ff @(posedge clock) begin
        last_req <= req;
    end

    always_ff @(posedge clock) begin
        if (ready && push) begin
            mem[wr_ptr] <= src_value;
        end
    end

    // Only one upstream request in flight; issuing only when count<DEPTH reserves its slot.
    always_ff @(posedge clock) begin
        if (!ready) begin
            state    <= IDLE;
            src_req  <= 1'b0;
            end_seen <= 1'b0;
            wr_ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!end_seen && (count < FULL)) begin
                        state   <= REQ;
                        src_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (src_ack) begin
                        state   <= GAP;
                        src_req <= 1'b0;
                        if (src_value_valid) begin
                            wr_ptr <= wr_ptr + PTR_ONE;
                        end else begin
                            end_seen <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    src_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!ready) begin
            count       <= '0;
            rd_ptr      <= '0;
            pending     <= 1'b0;
            ack         <= 1'b0;
            value       <= '0;
            value_valid <= 1'b0;
        end else begin
            ack <= pop || end_ack;
            if (pop) begin
                value       <= mem[rd_ptr];
                value_valid <= 1'b1;
                rd_ptr      <= rd_ptr + PTR_ONE;
            end else if (end_ack) begin
                value_valid <= 1'b0;
            end
            // A new edge while a request is still pending is merged into it.
            if (pending) begin
                pending <= !(pop || end_ack);
            end else begin
                pending <= req_edge;
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef LIST_PREFETCH_COUNT_EN
    always_ff @(posedge clock) begin
        if (!ready) begin
            delivered <= '0;
        end else if (pop && (delivered != 16'hFFFF)) begin
            delivered <= delivered + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_list_prefetch.sv
// tb_list_prefetch: randomized bench for list_prefetch with an upstream list agent and a list-level reference model.
`timescale 1ns/1ps
module tb_list_prefetch;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clock = 1'b0;
    logic             ready = 1'b0;
    logic             req = 1'b0;
    logic             src_req;
    logic             src_ack;
    logic [WIDTH-1:0] src_value;
    logic             src_value_valid;
    logic             ack;
    logic [WIDTH-1:0] value;
    logic             value_valid;
`ifdef LIST_PREFETCH_COUNT_EN
    logic [15:0]      delivered;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: the upstream list, and the cycle each element (and the end marker) was handed over.
    int up_list[$];
    int up_idx = 0;
    int wr_cyc[$];
    bit end_known = 0;
    int end_cyc = 0;
    int up_delay = 0;
    bit up_rand = 0;
    bit up_manual = 0;

    int   up_reqs = 0;
    int   ack_count = 0;
    int   acks_expected = 0;
    logic src_req_q = 1'b0;

    list_prefetch #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clock           (clock),
        .ready           (ready),
        .src_req         (src_req),
        .src_ack         (src_ack),
        .src_value       (src_value),
        .src_value_valid (src_value_valid),
        .req             (req),
        .ack             (ack),
        .value           (value),
        .value_valid     (value_valid)
`ifdef LIST_PREFETCH_COUNT_EN
        ,
        .delivered       (delivered)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (ack === 1'b1) ack_count++;
        if (src_req === 1'b1 && src_req_q !== 1'b1) up_reqs++;
        src_req_q = src_req;
    end

    // Upstream list producer: answers each request with a one-cycle ack after a delay.
    initial begin : upstream
        int  wait_cnt;
        bit  busy;
        busy = 0;
        wait_cnt = 0;
        src_ack = 1'b0;
        src_value = '0;
        src_value_valid = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (up_manual) begin
                busy = 0;
            end else if (src_ack) begin
                src_ack = 1'b0;
                src_value_valid = 1'b0;
                busy = 0;
            end else if (src_req === 1'b1) begin
                if (!busy) begin
                    busy = 1;
                    wait_cnt = up_rand ? int'($urandom_range(0, 4)) : up_delay;
                end
                if (wait_cnt == 0) begin
                    src_ack = 1'b1;
                    if (up_idx < up_list.size()) begin
                        src_value = WIDTH'(up_list[up_idx]);
                        src_value_valid = 1'b1;
                        wr_cyc.push_back(cyc + 1);
                        up_idx++;
                    end else begin
                        src_value = WIDTH'($urandom);
                        src_value_valid = 1'b0;
                        end_known = 1;
                        end_cyc = cyc + 1;
                    end
                end else begin
                    wait_cnt--;
                end
            end else begin
                busy = 0;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("[TB] FAIL watchdog got no finish want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The k-th element is acked one cycle after both its request edge and its arrival upstream.
    function automatic int exp_cycle(input int k, input int e);
        if (k < up_list.size()) begin
            return (k < wr_cyc.size()) ? imax(e, wr_cyc[k]) + 1 : -1;
        end
        return end_known ? imax(e, end_cyc) + 1 : -1;
    endfunction

    task automatic restart(input int len, input int base);
        @(posedge clock);
        #1;
        ready = 1'b0;
        req = 1'b0;
        @(posedge clock);
        #1;
        up_list.delete();
        for (int i = 0; i < len; i++) up_list.push_back(base + i);
        up_idx = 0;
        wr_cyc.delete();
        end_known = 0;
        up_reqs = 0;
        ack_count = 0;
        acks_expected = 0;
        ready = 1'b1;
    endtask

    task automatic pull(output bit got, output logic [WIDTH-1:0] v, output logic vv,
                        output int e, output int s);
        got = 0;
        v = '0;
        vv = 1'b0;
        s = -1;
        @(posedge clock);
        #1;
        req = 1'b1;
        e = cyc + 1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clock);
            if (ack === 1'b1) begin
                got = 1;
                v = value;
                vv = value_valid;
                s = cyc;
            end
        end
        if (got) acks_expected++;
        @(posedge clock);
        #1;
        req = 1'b0;
    endtask

    task automatic test_reset();
        ready = 1'b0;
        req = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (src_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_src_req got %b want 0", src_req); end
        checks++;
        if (ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack got %b want 0", ack); end
        checks++;
        if (value !== '0) begin errors++; $display("[TB] FAIL reset_value got %0d want 0", value); end
        checks++;
        if (value_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", value_valid); end
    endtask

    task automatic test_enumerate();
        bit got; logic [WIDTH-1:0] v; logic vv; int e; int s;
        up_rand = 0;
        up_delay = 0;
        restart(3, 1);
        repeat (30) @(posedge clock);
        @(negedge clock);
        checks++;
        if (up_reqs !== 4) begin errors++; $display("[TB] FAIL enum_requests got %0d want 4", up_reqs); end
        checks++;
        if (src_req !== 1'b0) begin errors++; $display("[TB] FAIL enum_idle_src_req got %b want 0", src_req); end
        for (int k = 0; k < 4; k++) begin
            pull(got, v, vv, e, s);
            checks++;
            if (!got) begin
                errors++; $display("[TB] FAIL enum_timeout got no ack want ack for pull %0d", k);
            end else begin
                checks++;
                if (k < 3 && (vv !== 1'b1 || v !== WIDTH'(k + 1))) begin
                    errors++; $display("[TB] FAIL enum_data got %b/%0d want 1/%0d", vv, v, k + 1);
                end else if (k == 3 && vv !== 1'b0) begin
                    errors++; $display("[TB] FAIL enum_end got valid %b want 0", vv);
                end
                checks++;
                if (s !== e + 1) begin errors++; $display("[TB] FAIL enum_latency got cycle %0d want %0d", s, e + 1); end
            end
        end
        checks++;
        if (ack_count !== acks_expected) begin
            errors++; $display("[TB] FAIL enum_ack_count got %0d want %0d", ack_count, acks_expected);
        end
    endtask

    task automatic test_stall();
        bit got; logic [WIDTH-1:0] v; logic vv; int e; int s; int exp_s;
        up_rand = 0;
        up_delay = 0;
        restart(10, 10);
        repeat (40) @(posedge clock);
        @(negedge clock);
        checks++;
        if (up_reqs !== DEPTH) begin errors++; $display("[TB] FAIL stall_requests got %0d want %0d", up_reqs, DEPTH); end
        checks++;
        if (src_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_src_req got %b want 0", src_req); end
        pull(got, v, vv, e, s);
        checks++;
        if (!got || vv !== 1'b1 || v !== 8'd10 || s !== e + 1) begin
            errors++; $display("[TB] FAIL stall_first_pop got ack %b %b/%0d cycle %0d want ack 1 1/10 cycle %0d", got, vv, v, s, e + 1);
        end
        repeat (30) @(posedge clock);
        @(negedge clock);
        checks++;
        if (up_reqs !== DEPTH + 1) begin errors++; $display("[TB] FAIL stall_refill got %0d want %0d", up_reqs, DEPTH + 1); end
        up_rand = 1;
        for (int k = 1; k <= 10; k++) begin
            repeat ($urandom_range(0, 5)) @(posedge clock);
            pull(got, v, vv, e, s);
            exp_s = exp_cycle(k, e);
            checks++;
            if (!got) begin
                errors++; $display("[TB] FAIL stall_timeout got no ack want ack for pull %0d", k);
            end else begin
                checks++;
                if (k < 10 && (vv !== 1'b1 || v !== WIDTH'(up_list[k]))) begin
                    errors++; $display("[TB] FAIL stall_data got %b/%0d want 1/%0d", vv, v, up_list[k]);
                end else if (k == 10 && vv !== 1'b0) begin
                    errors++; $display("[TB] FAIL stall_end got valid %b want 0", vv);
                end
                checks++;
                if (s !== exp_s) begin errors++; $display("[TB] FAIL stall_latency got cycle %0d want %0d", s, exp_s); end
            end
        end
    endtask

    task automatic test_empty();
        bit got; logic [WIDTH-1:0] v; logic vv; int e; int s;
        up_rand = 0;
        up_delay = 0;
        restart(0, 0);
        repeat (10) @(posedge clock);
        for (int k = 0; k < 4; k++) begin
            pull(got, v, vv, e, s);
            checks++;
            if (!got || vv !== 1'b0 || v !== '0) begin
                errors++; $display("[TB] FAIL empty_end got ack %b %b/%0d want ack 1 0/0", got, vv, v);
            end
            checks++;
            if (s !== e + 1) begin errors++; $display("[TB] FAIL empty_latency got cycle %0d want %0d", s, e + 1); end
        end
        checks++;
        if (up_reqs !== 1) begin errors++; $display("[TB] FAIL empty_requests got %0d want 1", up_reqs); end
    endtask

    task automatic test_delayed();
        bit got; logic [WIDTH-1:0] v; logic vv; int e; int s; int exp_s;
        up_rand = 0;
        up_delay = 5;
        restart(3, 42);
        pull(got, v, vv, e, s);
        exp_s = exp_cycle(0, e);
        checks++;
        if (!got || vv !== 1'b1 || v !== 8'd42) begin
            errors++; $display("[TB] FAIL delayed_data got ack %b %b/%0d want ack 1 1/42", got, vv, v);
        end
        checks++;
        if (s !== exp_s || s <= e + 1) begin
            errors++; $display("[TB] FAIL delayed_latency got cycle %0d want %0d", s, exp_s);
        end
        checks++;
        if (ack_count !== acks_expected) begin
            errors++; $display("[TB] FAIL delayed_ack_count got %0d want %0d", ack_count, acks_expected);
        end
        up_delay = 0;
    endtask

    task automatic test_reset_mid();
        bit got; logic [WIDTH-1:0] v; logic vv; int e; int s; int exp_s; bit found;
        up_rand = 0;
        up_delay = 6;
        restart(5, 1);
        pull(got, v, vv, e, s);
        checks++;
        if (!got || v !== 8'd1) begin errors++; $display("[TB] FAIL midrst_pre_pop got ack %b value %0d want ack 1 value 1", got, v); end
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clock);
            #1;
            if (wr_cyc.size() == 3 && src_req === 1'b1 && src_ack === 1'b0) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL midrst_setup got no outstanding request want one with two buffered"); end
        up_manual = 1;
        src_ack = 1'b1;
        src_value = 8'd99;
        src_value_valid = 1'b1;
        ready = 1'b0;
        @(posedge clock);
        #1;
        ready = 1'b1;
        src_ack = 1'b0;
        src_value_valid = 1'b0;
        src_value = '0;
        up_idx = 0;
        wr_cyc.delete();
        end_known = 0;
        up_delay = 0;
        ack_count = 0;
        acks_expected = 0;
        up_manual = 0;
        @(negedge clock);
        checks++;
        if (src_req !== 1'b0 || ack !== 1'b0 || value !== '0 || value_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_outputs got req %b ack %b value %0d valid %b want 0 0 0 0", src_req, ack, value, value_valid);
        end
        for (int k = 0; k < 3; k++) begin
            pull(got, v, vv, e, s);
            exp_s = exp_cycle(k, e);
            checks++;
            if (!got || vv !== 1'b1 || v !== WIDTH'(k + 1)) begin
                errors++; $display("[TB] FAIL midrst_refetch got ack %b %b/%0d want ack 1 1/%0d", got, vv, v, k + 1);
            end
            checks++;
            if (s !== exp_s) begin errors++; $display("[TB] FAIL midrst_latency got cycle %0d want %0d", s, exp_s); end
        end
    endtask

    task automatic test_random();
        bit got; logic [WIDTH-1:0] v; logic vv; int e; int s; int exp_s; int len;
        for (int round = 0; round < 6; round++) begin
            len = $urandom_range(0, 9);
            up_rand = 1;
            restart(len, $urandom_range(0, 200));
            repeat ($urandom_range(0, 12)) @(posedge clock);
            for (int k = 0; k < len + 2; k++) begin
                repeat ($urandom_range(0, 5)) @(posedge clock);
                pull(got, v, vv, e, s);
                exp_s = exp_cycle(k, e);
                checks++;
                if (!got) begin
                    errors++; $display("[TB] FAIL rand_timeout got no ack want ack for pull %0d", k);
                end else begin
                    checks++;
                    if (k < len && (vv !== 1'b1 || v !== WIDTH'(up_list[k]))) begin
                        errors++; $display("[TB] FAIL rand_data got %b/%0d want 1/%0d", vv, v, up_list[k]);
                    end else if (k >= len && vv !== 1'b0) begin
                        errors++; $display("[TB] FAIL rand_end got valid %b want 0", vv);
                    end
                    checks++;
                    if (s !== exp_s) begin errors++; $display("[TB] FAIL rand_latency got cycle %0d want %0d", s, exp_s); end
                end
            end
            repeat (3) @(posedge clock);
            @(negedge clock);
            checks++;
            if (ack_count !== acks_expected) begin
                errors++; $display("[TB] FAIL rand_ack_count got %0d want %0d", ack_count, acks_expected);
            end
        end
        up_rand = 0;
    endtask

`ifdef LIST_PREFETCH_COUNT_EN
    task automatic test_delivered();
        bit got; logic [WIDTH-1:0] v; logic vv; int e; int s;
        up_rand = 0;
        up_delay = 0;
        restart(3, 1);
        for (int k = 0; k < 4; k++) pull(got, v, vv, e, s);
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if (delivered !== 16'd3) begin errors++; $display("[TB] FAIL delivered_count got %0d want 3", delivered); end
        @(posedge clock);
        #1;
        ready = 1'b0;
        @(negedge clock);
        checks++;
        if (delivered !== 16'd0) begin errors++; $display("[TB] FAIL delivered_clear got %0d want 0", delivered); end
        ready = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_enumerate();
        test_stall();
        test_empty();
        test_delayed();
        test_reset_mid();
        test_random();
`ifdef LIST_PREFETCH_COUNT_EN
        test_delivered();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/list_prefetch.md
Name: list_prefetch

Overview:
- Buffering stage placed between a list producer (enumerator, cons, concat, list mux) and its consumer.
- Fetches elements from the upstream list ahead of demand into a DEPTH-entry FIFO.
- Serves downstream requests from the FIFO, so consumer latency is one cycle whenever data is buffered.
- Both sides use the standard list handshake: a rising edge on req yields one ack pulse carrying value/value_valid; value_valid=0 marks end of list.

Parameters:
- WIDTH, 8, element width in bits.
- DEPTH, 4, FIFO entries (power of two, >=2).
- AW, 2, FIFO pointer width (log2 DEPTH).

Ports:
- clock  input  1  system clock, all state on posedge.
- ready  input  1  synchronous active-low reset; low clears all state, high runs.
- src_req  output  1  upstream request (rising edge requests one element).
- src_ack  input  1  upstream acknowledge; may be registered or combinational.
- src_value  input  WIDTH  upstream element.
- src_value_valid  input  1  upstream element valid; 0 means end of list.
- req  input  1  downstream request (rising edge = one element wanted).
- ack  output  1  downstream acknowledge, one-cycle pulse.
- value  output  WIDTH  downstream element.
- value_valid  output  1  1 = element, 0 = end of list.

Behaviour:
- Reset (ready=0 at posedge): count=0, rd/wr pointers=0, end_seen=0, fetch FSM=IDLE, pending=0, src_req=0, ack=0, value=0, value_valid=0.
- lastReq <= req every cycle regardless of ready, so a req held high across reset release is not an edge.
- Fetch FSM (src_req registered):
  - IDLE: if ready & ~end_seen & count<DEPTH, go to REQ with src_req<=1.
  - REQ: hold src_req=1 until src_ack=1 is sampled. Then src_req<=0 and go to GAP.
    - On that ack, if src_value_valid=1, write src_value at wr_ptr and increment count.
    - If src_value_valid=0, set end_seen; nothing is written.
  - GAP: one cycle with src_req=0 (guarantees the next rising edge), then IDLE.
  - At most one upstream request is outstanding. The count<DEPTH check at issue reserves the slot, so a write never overflows.
- Downstream:
  - req & ~lastReq sets pending.
  - When pending & count>0: pop rd_ptr, then value<=data, value_valid<=1, ack<=1 for one cycle, pending<=0.
  - When pending & count==0 & end_seen: ack<=1, value_valid<=0, value unchanged, pending<=0. This repeats for every later request (sticky end).
  - When pending & count==0 & ~end_seen: wait. No bypass; ack comes one cycle after the element is written.
  - ack is 0 in all other cycles.
- Latency:
  - Buffered element: ack in the cycle after the req rising edge.
  - Empty FIFO: ack 1 cycle after the upstream write cycle.
- Simultaneous push and pop in the same cycle: count is unchanged and both pointers advance. A pop and a push of the last free slot may coincide.
- A second rising edge on req while pending=1 is merged (consumer protocol violation; no extra ack).
- Reset mid-operation: all buffered data and the outstanding request are discarded. A src_ack arriving while ready=0 or in IDLE/GAP is ignored.
- Pointers wrap modulo DEPTH. count has width AW+1.

Optional Feature:
- Macro LIST_PREFETCH_COUNT_EN.
- Defined: adds output port delivered [15:0], counting acks issued with value_valid=1. It saturates at 16'hFFFF and is cleared while ready=0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Upstream enumerator 1..3 (step 1), DEPTH=4, ready raised with consumer idle:
  - Expected: exactly 4 upstream requests, count=3, end_seen=1, src_req stays 0 afterwards.
  - Then 4 consumer req pulses -> values 1, 2, 3 with value_valid=1, each ack 1 cycle after the req edge, then ack with value_valid=0.
- Upstream list 10..19, DEPTH=4, no consumer:
  - Expected: fetching stalls at count=4 with src_req=0.
  - One consumer pop returns 10, after which exactly one new upstream request is issued.
- Empty upstream list (first ack has valid=0), then consumer req -> ack with value_valid=0 one cycle after the edge. Three further reqs -> three further end acks.
- Upstream ack delayed 5 cycles, consumer req on an empty FIFO -> ack exactly 1 cycle after the upstream write with value=first element. No ack earlier.
- Drop ready for 1 cycle while src_req=1 and count=2, with src_ack arriving during the reset cycle:
  - Expected: all outputs return to reset values and the stale ack is not stored.
  - After ready returns, refetching starts from the upstream's restarted first element.
- With LIST_PREFETCH_COUNT_EN, deliver 1..3 plus the end marker -> delivered=3. Drop ready -> delivered=0.
